// File: rtl/si_to_nt_wb.sv
// si_to_nt_wb: registered single-initiator to N-target WISHBONE traffic cop
// with table-driven decode, bus-error response, ack watchdog and error status.
//
// Ports:
//   wb_clk_i, wb_rst_n_i      clock, asynchronous active-low reset
//   i_wb_*                    initiator side (cyc/stb/adr/sel/we/dat in,
//                             dat/ack/err out)
//   t_wb_cyc_o, t_wb_stb_o    per-target one-hot cycle/strobe
//   t_wb_adr/sel/we/dat_o     shared latched request fields
//   t_wb_dat_i, t_wb_ack_i    per-target read data (k*DW +: DW) and acks
//   err_cnt_o, err_adr_o      saturating error count, last error address
//   err_clr_i                 synchronous clear of the error status
module si_to_nt_wb #(
    parameter int unsigned NUM_T    = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned PREFIX_W = 8,
    parameter int unsigned SUFFIX_W = 4,
    parameter logic [PREFIX_W-1:0] T0_PREFIX    = 8'h00,
    parameter logic [PREFIX_W-1:0] ACCEL_PREFIX = 8'h9d,
    parameter logic [(NUM_T-1)*SUFFIX_W-1:0] T_SUFFIXES = {4'h2, 4'h1, 4'h0},
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  i_wb_cyc_i,
    input  logic                  i_wb_stb_i,
    input  logic [AW-1:0]         i_wb_adr_i,
    input  logic [DW/8-1:0]       i_wb_sel_i,
    input  logic                  i_wb_we_i,
    input  logic [DW-1:0]         i_wb_dat_i,
    output logic [DW-1:0]         i_wb_dat_o,
    output logic                  i_wb_ack_o,
    output logic                  i_wb_err_o,
    output logic [NUM_T-1:0]      t_wb_cyc_o,
    output logic [NUM_T-1:0]      t_wb_stb_o,
    output logic [AW-1:0]         t_wb_adr_o,
    output logic [DW/8-1:0]       t_wb_sel_o,
    output logic                  t_wb_we_o,
    output logic [DW-1:0]         t_wb_dat_o,
    input  logic [NUM_T*DW-1:0]   t_wb_dat_i,
    input  logic [NUM_T-1:0]      t_wb_ack_i,
    output logic [7:0]            err_cnt_o,
    output logic [AW-1:0]         err_adr_o,
    input  logic                  err_clr_i
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t state;

    logic [PREFIX_W-1:0] prefix;
    logic [SUFFIX_W-1:0] suffix;
    logic [NUM_T-1:0]    dec_sel;
    logic                dec_found;
    logic [DW-1:0]       rd_mux;
    logic                ack_hit;
    logic [15:0]         wd_cnt;

    assign prefix = i_wb_adr_i[AW-1 -: PREFIX_W];
    assign suffix = i_wb_adr_i[AW-PREFIX_W-1 -: SUFFIX_W];

    // Target decode; the first matching suffix entry wins on duplicates.
    always_comb begin
        dec_sel   = '0;
        dec_found = 1'b0;
        if (prefix == T0_PREFIX) begin
            dec_sel[0] = 1'b1;
        end else if (prefix == ACCEL_PREFIX) begin
            for (int k = 0; k < NUM_T - 1; k++) begin
                if (!dec_found &&
                    suffix == T_SUFFIXES[k*SUFFIX_W +: SUFFIX_W]) begin
                    dec_sel[k+1] = 1'b1;
                    dec_found    = 1'b1;
                end
            end
        end
    end

    // t_wb_cyc_o is only non-zero in REQ and then equals the captured
    // select, so it doubles as the ack/data qualifier. Acks from other
    // targets, or in any other state, fall out of the mask.
    assign ack_hit = |(t_wb_ack_i & t_wb_cyc_o);

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_T; k++) begin
            if (t_wb_cyc_o[k]) begin
                rd_mux = rd_mux | t_wb_dat_i[k*DW +: DW];
            end
        end
    end

    assign t_wb_stb_o = t_wb_cyc_o;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= IDLE;
            t_wb_cyc_o <= '0;
            t_wb_adr_o <= '0;
            t_wb_sel_o <= '0;
            t_wb_we_o  <= 1'b0;
            t_wb_dat_o <= '0;
            i_wb_dat_o <= '0;
            i_wb_ack_o <= 1'b0;
            i_wb_err_o <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            i_wb_ack_o <= 1'b0;
            i_wb_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_wb_cyc_i && i_wb_stb_i) begin
                        t_wb_adr_o <= i_wb_adr_i;
                        t_wb_sel_o <= i_wb_sel_i;
                        t_wb_we_o  <= i_wb_we_i;
                        t_wb_dat_o <= i_wb_dat_i;
                        wd_cnt     <= '0;
                        if (|dec_sel) begin
                            t_wb_cyc_o <= dec_sel;
                            state      <= REQ;
                        end else begin
                            i_wb_err_o <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (!i_wb_cyc_i) begin
                        // Initiator abort: release quietly.
                        t_wb_cyc_o <= '0;
                        state      <= IDLE;
                    end else if (ack_hit) begin
                        if (!t_wb_we_o) begin
                            i_wb_dat_o <= rd_mux;
                        end
                        t_wb_cyc_o <= '0;
                        i_wb_ack_o <= 1'b1;
                        state      <= RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        t_wb_cyc_o <= '0;
                        i_wb_err_o <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status follows the visible err pulse; a clear in that same cycle wins.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            err_cnt_o <= '0;
            err_adr_o <= '0;
        end else if (err_clr_i) begin
            err_cnt_o <= '0;
            err_adr_o <= '0;
        end else if (i_wb_err_o) begin
            if (err_cnt_o != 8'hff) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
            err_adr_o <= t_wb_adr_o;
        end
    end

    prefix_distinct: assert property (
        @(posedge wb_clk_i) disable iff (!wb_rst_n_i)
        T0_PREFIX != ACCEL_PREFIX
    );

    resp_exclusive: assert property (
        @(posedge wb_clk_i) disable iff (!wb_rst_n_i)
        !(i_wb_ack_o && i_wb_err_o)
    );

    target_onehot: assert property (
        @(posedge wb_clk_i) disable iff (!wb_rst_n_i)
        $onehot0(t_wb_cyc_o)
    );

endmodule

// File: tb/tb_si_to_nt_wb.sv
// tb_si_to_nt_wb: directed bench for si_to_nt_wb with a cycle-indexed
// expectation schedule derived from the transfer latencies.
module tb_si_to_nt_wb;

    localparam int NT = 4;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_cyc, i_stb, i_we;
    logic [31:0]   i_adr, i_dat;
    logic [3:0]    i_sel;
    logic [31:0]   i_dat_o;
    logic          i_ack_o, i_err_o;
    logic [3:0]    t_cyc_o, t_stb_o;
    logic [31:0]   t_adr_o, t_dat_o;
    logic [3:0]    t_sel_o;
    logic          t_we_o;
    logic [127:0]  t_dat_i;
    logic [3:0]    t_ack;
    logic [7:0]    err_cnt;
    logic [31:0]   err_adr;
    logic          clr_i;
    logic [31:0]   rd_data [NT];

    assign t_dat_i = {rd_data[3], rd_data[2], rd_data[1], rd_data[0]};

    si_to_nt_wb dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .i_wb_cyc_i (i_cyc),
        .i_wb_stb_i (i_stb),
        .i_wb_adr_i (i_adr),
        .i_wb_sel_i (i_sel),
        .i_wb_we_i  (i_we),
        .i_wb_dat_i (i_dat),
        .i_wb_dat_o (i_dat_o),
        .i_wb_ack_o (i_ack_o),
        .i_wb_err_o (i_err_o),
        .t_wb_cyc_o (t_cyc_o),
        .t_wb_stb_o (t_stb_o),
        .t_wb_adr_o (t_adr_o),
        .t_wb_sel_o (t_sel_o),
        .t_wb_we_o  (t_we_o),
        .t_wb_dat_o (t_dat_o),
        .t_wb_dat_i (t_dat_i),
        .t_wb_ack_i (t_ack),
        .err_cnt_o  (err_cnt),
        .err_adr_o  (err_adr),
        .err_clr_i  (clr_i)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc_no = 0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h want %0h",
                     nm, cyc_no, act, exp);
        end
    endtask

    // Expected outputs, keyed by cycle number (cycle c follows posedge c).
    logic [3:0]  exp_tcyc [int];
    bit          exp_ack  [int];
    bit          exp_err  [int];
    logic [31:0] exp_dat  [int];
    logic [31:0] err_at   [int];

    logic [31:0] m_adr, m_wdat, m_dat, m_eadr;
    logic [3:0]  m_sel;
    logic        m_we;
    int          m_cnt;
    int          t1_hi;

    logic [3:0] sfx [3] = '{4'h0, 4'h1, 4'h2};

    function automatic int decode(input logic [31:0] a);
        if (a[31:24] == 8'h00) return 0;
        if (a[31:24] == 8'h9d) begin
            for (int k = 0; k < 3; k++) begin
                if (a[23:20] == sfx[k]) return k + 1;
            end
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int c;
        logic [3:0] et;
        bit ea, ee;
        c = cyc_no;
        if (!rst_n) begin
            m_cnt = 0;
            m_eadr = '0;
            m_dat = '0;
            chk("rst_tcyc", 64'(t_cyc_o), 64'(0));
            chk("rst_ack", 64'(i_ack_o), 64'(0));
            chk("rst_err", 64'(i_err_o), 64'(0));
            chk("rst_dat", 64'(i_dat_o), 64'(0));
            chk("rst_cnt", 64'(err_cnt), 64'(0));
            chk("rst_tadr", 64'(t_adr_o), 64'(0));
        end else begin
            et = exp_tcyc.exists(c) ? exp_tcyc[c] : 4'h0;
            ea = exp_ack.exists(c);
            ee = exp_err.exists(c);
            if (exp_dat.exists(c)) m_dat = exp_dat[c];
            chk("tcyc", 64'(t_cyc_o), 64'(et));
            chk("tstb", 64'(t_stb_o), 64'(et));
            chk("ack", 64'(i_ack_o), 64'(ea));
            chk("err", 64'(i_err_o), 64'(ee));
            chk("rdat", 64'(i_dat_o), 64'(m_dat));
            chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
            chk("err_adr", 64'(err_adr), 64'(m_eadr));
            if (et != 4'h0) begin
                chk("tadr", 64'(t_adr_o), 64'(m_adr));
                chk("twe", 64'(t_we_o), 64'(m_we));
                chk("tsel", 64'(t_sel_o), 64'(m_sel));
                if (m_we) chk("twdat", 64'(t_dat_o), 64'(m_wdat));
            end
            if (t_cyc_o[1]) t1_hi++;
            if (clr_i) begin
                m_cnt = 0;
                m_eadr = '0;
            end else if (ee) begin
                if (m_cnt < 255) m_cnt++;
                m_eadr = err_at[c];
            end
        end
    end

    task automatic to_cycle(input int c);
        while (cyc_no < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One initiator transfer. w: REQ cycles before the target acks
    // (0 = first REQ cycle, -1 = never). abrt: REQ cycle in which cyc drops.
    task automatic xfer(input logic [31:0] a, input logic w_e,
                        input logic [31:0] wd, input logic [3:0] s,
                        input int w, input int abrt,
                        input logic [3:0] spur, input bit clr);
        int n, t, last;
        n = cyc_no + 1;
        t = decode(a);
        i_cyc = 1'b1; i_stb = 1'b1;
        i_adr = a; i_we = w_e; i_dat = wd; i_sel = s;
        m_adr = a; m_we = w_e; m_wdat = wd; m_sel = s;
        if (t < 0) begin
            exp_err[n] = 1'b1;
            err_at[n] = a;
            last = n;
        end else if (abrt > 0) begin
            for (int c = n; c < n + abrt; c++) exp_tcyc[c] = 4'(1 << t);
            to_cycle(n);
            t_ack = spur;
            to_cycle(n + abrt - 1);
            i_cyc = 1'b0; i_stb = 1'b0;
            to_cycle(n + abrt);
            t_ack = 4'(1 << t);
            to_cycle(n + abrt + 1);
            t_ack = '0;
            return;
        end else if (w < 0 || w >= TO) begin
            for (int c = n; c < n + TO; c++) exp_tcyc[c] = 4'(1 << t);
            last = n + TO;
            exp_err[last] = 1'b1;
            err_at[last] = a;
            to_cycle(n);
            t_ack = spur;
            to_cycle(last);
            t_ack = 4'(1 << t);
        end else begin
            for (int c = n; c <= n + w; c++) exp_tcyc[c] = 4'(1 << t);
            last = n + w + 1;
            exp_ack[last] = 1'b1;
            if (!w_e) exp_dat[last] = rd_data[t];
            to_cycle(n);
            t_ack = spur;
            to_cycle(n + w);
            t_ack = spur | 4'(1 << t);
            to_cycle(last);
            t_ack = '0;
        end
        if (clr) begin
            to_cycle(last);
            clr_i = 1'b1;
        end
        to_cycle(last + 1);
        t_ack = '0; i_cyc = 1'b0; i_stb = 1'b0; clr_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat = '0;
        i_sel = '0; t_ack = '0; clr_i = 0;
        rd_data[0] = 32'hDEAD_BEEF;
        rd_data[1] = 32'h1111_0001;
        rd_data[2] = 32'hA5A5_0002;
        rd_data[3] = 32'h3333_0003;
        m_adr = '0; m_wdat = '0; m_sel = '0; m_we = 0;
        m_dat = '0; m_eadr = '0; m_cnt = 0; t1_hi = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(32'h0000_0010, 1'b0, 32'h0, 4'hf, 0, 0, 4'h0, 0);
        chk("lit_t0_read", 64'(i_dat_o), 64'h0000_0000_DEAD_BEEF);

        xfer(32'h9d20_0004, 1'b1, 32'h1234_5678, 4'b0011, 1, 0, 4'b0001, 0);
        chk("lit_w_adr", 64'(t_adr_o), 64'h9d20_0004);
        chk("lit_w_we", 64'(t_we_o), 64'h1);
        chk("lit_w_sel", 64'(t_sel_o), 64'h3);
        chk("lit_w_dat", 64'(t_dat_o), 64'h1234_5678);
        chk("lit_w_keep", 64'(i_dat_o), 64'hDEAD_BEEF);

        xfer(32'h9d10_0008, 1'b0, 32'h0, 4'hf, 2, 0, 4'b1000, 0);
        chk("lit_t2_read", 64'(i_dat_o), 64'hA5A5_0002);
        xfer(32'h9d00_000C, 1'b0, 32'h0, 4'hf, 0, 0, 4'h0, 0);
        chk("lit_t1_read", 64'(i_dat_o), 64'h1111_0001);

        xfer(32'h9df0_0000, 1'b0, 32'h0, 4'hf, 0, 0, 4'h0, 0);
        xfer(32'h4000_0000, 1'b1, 32'h5, 4'hf, 0, 0, 4'h0, 0);
        chk("lit_miss_cnt", 64'(err_cnt), 64'd2);
        chk("lit_miss_adr", 64'(err_adr), 64'h4000_0000);

        t1_hi = 0;
        xfer(32'h9d00_0000, 1'b0, 32'h0, 4'hf, -1, 0, 4'b0001, 0);
        chk("lit_to_cycles", 64'(t1_hi), 64'd255);
        chk("lit_to_cnt", 64'(err_cnt), 64'd3);
        chk("lit_to_adr", 64'(err_adr), 64'h9d00_0000);

        rd_data[0] = 32'hCAFE_F00D;
        xfer(32'h0000_0020, 1'b0, 32'h0, 4'hf, 0, 3, 4'h0, 0);
        chk("lit_abort_cnt", 64'(err_cnt), 64'd3);
        chk("lit_abort_dat", 64'(i_dat_o), 64'h1111_0001);
        xfer(32'h0000_0024, 1'b0, 32'h0, 4'hf, 0, 0, 4'h0, 0);
        chk("lit_after_abort", 64'(i_dat_o), 64'hCAFE_F00D);

        n = cyc_no + 1;
        i_cyc = 1; i_stb = 1; i_adr = 32'h0000_0030; i_we = 0; i_sel = 4'hf;
        m_adr = 32'h0000_0030; m_we = 0; m_sel = 4'hf;
        exp_tcyc[n] = 4'b0001;
        exp_tcyc[n+1] = 4'b0001;
        to_cycle(n + 1);
        #2;
        exp_tcyc.delete(); exp_ack.delete(); exp_err.delete();
        exp_dat.delete(); err_at.delete();
        rst_n = 1'b0;
        #1;
        chk("lit_arst_cyc", 64'(t_cyc_o), 64'd0);
        chk("lit_arst_dat", 64'(i_dat_o), 64'd0);
        chk("lit_arst_cnt", 64'(err_cnt), 64'd0);
        chk("lit_arst_adr", 64'(t_adr_o), 64'd0);
        i_cyc = 0; i_stb = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 260; i++) begin
            xfer(32'h4000_0000 + 32'(i * 4), 1'b0, 32'h0, 4'hf, 0, 0, 4'h0, 0);
        end
        chk("lit_sat_cnt", 64'(err_cnt), 64'd255);
        chk("lit_sat_adr", 64'(err_adr), 64'h4000_040C);

        xfer(32'h8000_0000, 1'b0, 32'h0, 4'hf, 0, 0, 4'h0, 1);
        chk("lit_clr_cnt", 64'(err_cnt), 64'd0);
        chk("lit_clr_adr", 64'(err_adr), 64'd0);

        xfer(32'h9d20_0000, 1'b0, 32'h0, 4'hf, 0, 0, 4'h0, 0);
        chk("lit_final_read", 64'(i_dat_o), 64'h3333_0003);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/si_to_nt_wb.md
Name: si_to_nt_wb

Overview:
- Registered single-initiator to N-target WISHBONE traffic cop. It is the parametrised successor to the fixed three-target cop in the subsoc.
- Sits between the OR1200 data master and the SRAM, SFIFO_IF, SSIF and future accelerator slaves.
- Adds a configurable target count, table-driven prefix/suffix decode, a bus-error response for unmapped addresses, an ack-timeout watchdog and error status registers.

Parameters:
- NUM_T, 4, number of targets (min 2). Target 0 is the memory target; targets 1..NUM_T-1 are accelerator targets.
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- PREFIX_W, 8, address prefix width, taken from adr[AW-1 -: PREFIX_W].
- SUFFIX_W, 4, accelerator suffix width, taken from adr[AW-PREFIX_W-1 -: SUFFIX_W].
- T0_PREFIX, 8'h00, prefix that selects target 0.
- ACCEL_PREFIX, 8'h9d, prefix that enables suffix decode.
- T_SUFFIXES, {4'h2,4'h1,4'h0}, flat (NUM_T-1)*SUFFIX_W table. Entry k (bits k*SUFFIX_W +: SUFFIX_W) selects target k+1.
- TIMEOUT, 255, cycles to wait for a target ack before returning an error (1..65535).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- i_wb_cyc_i  in  1  initiator cycle
- i_wb_stb_i  in  1  initiator strobe
- i_wb_adr_i  in  AW  initiator address
- i_wb_sel_i  in  DW/8  byte selects
- i_wb_we_i  in  1  write enable
- i_wb_dat_i  in  DW  write data
- i_wb_dat_o  out  DW  read data
- i_wb_ack_o  out  1  transfer acknowledge
- i_wb_err_o  out  1  bus error (unmapped address or timeout)
- t_wb_cyc_o  out  NUM_T  per-target cycle
- t_wb_stb_o  out  NUM_T  per-target strobe
- t_wb_adr_o  out  AW  shared latched address
- t_wb_sel_o  out  DW/8  shared latched selects
- t_wb_we_o  out  1  shared latched write enable
- t_wb_dat_o  out  DW  shared latched write data
- t_wb_dat_i  in  NUM_T*DW  target read data; target k uses bits k*DW +: DW
- t_wb_ack_i  in  NUM_T  target acknowledges
- err_cnt_o  out  8  saturating error count
- err_adr_o  out  AW  address of the most recent error
- err_clr_i  in  1  synchronous clear of err_cnt_o and err_adr_o

Behaviour:
- Reset (wb_rst_n_i low, asynchronous) drives every output to 0 and puts the FSM in IDLE.
- Decode is evaluated on i_wb_adr_i in IDLE:
  - prefix == T0_PREFIX → target 0;
  - prefix == ACCEL_PREFIX and suffix equals table entry k → target k+1; on duplicate entries the lowest k wins;
  - anything else → miss.
  - T0_PREFIX == ACCEL_PREFIX is illegal; flag it with a simulation assertion.
- FSM states: IDLE, REQ, RESP.
  - IDLE: when i_wb_cyc_i & i_wb_stb_i, latch adr/sel/we/dat into the t_wb_* registers and capture the one-hot target select. On a hit, go to REQ and assert t_wb_cyc_o[sel]/t_wb_stb_o[sel] from the next cycle. On a miss, go to RESP with err pending; no target is touched.
  - REQ: hold cyc/stb on the selected target only.
    - On t_wb_ack_i[sel]: register t_wb_dat_i[sel] into i_wb_dat_o (reads only; writes leave it unchanged), drop target cyc/stb next cycle, go to RESP with ack pending.
    - Watchdog: counter is cleared on REQ entry and increments each REQ cycle. When it reaches TIMEOUT with no ack, drop the target and go to RESP with err pending.
    - Ack and timeout in the same cycle: the ack wins.
    - Acks from non-selected targets are ignored in every state.
  - RESP: assert exactly one of i_wb_ack_o / i_wb_err_o for one cycle, then return to IDLE. A still-asserted stb in the following IDLE cycle is treated as a new request.
- Latency: for a zero-wait target that acks in the first REQ cycle, i_wb_ack_o is asserted 2 cycles after the request is sampled. An unmapped access gets i_wb_err_o 1 cycle after sampling. A timeout gets err TIMEOUT+1 cycles after sampling.
- Initiator abort: if i_wb_cyc_i falls while in REQ, drop the target cyc/stb next cycle and return to IDLE with no ack or err. A late target ack after the abort is ignored.
- Error status: on each err pulse, err_cnt_o increments (saturating at 255) and err_adr_o loads the latched address. If err_clr_i coincides with an error, the clear wins and the count ends at 0.
- Only one outstanding transfer at a time; there are no bursts, and cti/bte are not supported.

Test Plan:
- Read 0x0000_0010, target 0 acks in the first REQ cycle with 0xDEADBEEF → t_wb_cyc_o=4'b0001 for 1 cycle; i_wb_ack_o 2 cycles after sampling with i_wb_dat_o=0xDEADBEEF.
- Write to 0x9d20_0004 (suffix 2), sel=4'b0011 → only t_wb_cyc_o[3] asserted; t_wb_adr_o=0x9d200004, t_wb_we_o=1, t_wb_sel_o=4'b0011; single ack returned.
- Access 0x9df0_0000 (unmapped suffix), then 0x4000_0000 → each gives i_wb_err_o for 1 cycle with no t_wb_cyc_o activity; err_cnt_o=2, err_adr_o=0x40000000.
- Target 1 never acks, TIMEOUT=255 → t_wb_cyc_o[1] high for 255 cycles, then i_wb_err_o; a late ack is ignored; err_cnt_o increments by 1.
- i_wb_cyc_i drops in the 3rd REQ cycle → target released the next cycle, no ack/err; the next access completes normally.
- Assert wb_rst_n_i low mid-REQ → all outputs 0 immediately (asynchronously); 260 error events → err_cnt_o=255; err_clr_i coincident with an error → err_cnt_o=0.
